// File: rtl/itlb_l0_pkg.sv
// Shared types for the L0 instruction TLB: main-TLB result record, FSM
// state encoding and the L0 tag match rule.
package itlb_l0_pkg;

  localparam int TLBIDLEN        = 4;
  localparam int ITLB_L0_ENTRIES = 4;
  localparam int VPPN_W          = 19;
  localparam int PPN_W           = 20;

  // Page size code that marks a 4MB page; those entries ignore the low
  // vppn bits and VA[12] when matching.
  localparam logic [5:0] PS_4MB = 6'd21;

  typedef struct packed {
    logic                found;
    logic [TLBIDLEN-1:0] index;
    logic [PPN_W-1:0]    ppn;
    logic [5:0]          ps;
    logic [1:0]          plv;
    logic [1:0]          mat;
    logic                d;
    logic                v;
  } tlb_result_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_RESP = 2'd2
  } itlb_state_t;

  // A 4MB entry compares vppn[18:8] only; a 4KB entry needs the full vppn
  // plus VA[12] (each vppn names an even/odd 4KB pair).
  function automatic logic tag_match(
    input logic [VPPN_W-1:0] req_vppn,
    input logic              req_bit12,
    input logic [VPPN_W-1:0] tag_vppn,
    input logic              tag_bit12,
    input logic              ps4mb
  );
    logic m;
    if (ps4mb) begin
      m = (req_vppn[18:8] == tag_vppn[18:8]);
    end else begin
      m = (req_vppn == tag_vppn) && (req_bit12 == tag_bit12);
    end
    return m;
  endfunction

endpackage

// File: rtl/itlb_l0_if.sv
// Bus between fetch address generation, the L0 ITLB and main-TLB search
// port 0.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; while req_valid is high and req_ready low the
// requester holds req_vppn/req_va_bit12 steady. resp_valid has no
// back-pressure: it is a single-cycle pulse the consumer must take as is.
// tlb_s0_result is the main TLB's combinational answer to tlb_s0_vppn /
// tlb_s0_va_bit12 in the same cycle.
interface itlb_l0_if;
  import itlb_l0_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [VPPN_W-1:0]   req_vppn;
  logic                req_va_bit12;
  logic                resp_valid;
  tlb_result_t         resp_result;
  logic                flush;
  logic [VPPN_W-1:0]   tlb_s0_vppn;
  logic                tlb_s0_va_bit12;
  tlb_result_t         tlb_s0_result;
  itlb_state_t         dbg_state;

  // L0 ITLB side.
  modport slave (
    input  req_valid, req_vppn, req_va_bit12, flush, tlb_s0_result,
    output req_ready, resp_valid, resp_result, tlb_s0_vppn, tlb_s0_va_bit12,
    output dbg_state
  );

  // Fetch / main-TLB side.
  modport master (
    output req_valid, req_vppn, req_va_bit12, flush, tlb_s0_result,
    input  req_ready, resp_valid, resp_result, tlb_s0_vppn, tlb_s0_va_bit12,
    input  dbg_state
  );

endinterface

// File: rtl/itlb_l0_cam.sv
// Tag store of the L0 ITLB: valid bits, tags, cached results, the
// match vector and an encoded hit index used to read the cached result.
module itlb_l0_cam
  import itlb_l0_pkg::*;
#(
  parameter int ENTRIES = ITLB_L0_ENTRIES,
  parameter int IDW     = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [IDW-1:0]      wr_idx,
  input  logic [VPPN_W-1:0]   wr_vppn,
  input  logic                wr_bit12,
  input  tlb_result_t         wr_result,
  input  logic [VPPN_W-1:0]   lk_vppn,
  input  logic                lk_bit12,
  output logic [ENTRIES-1:0]  hit_vec,
  output logic [IDW-1:0]      hit_id,
  input  logic [IDW-1:0]      rd_id,
  output tlb_result_t         rd_result
);

  logic [ENTRIES-1:0] valid_q;
  logic [VPPN_W-1:0]  tag_vppn_q [ENTRIES];
  logic [ENTRIES-1:0] tag_bit12_q;
  logic [ENTRIES-1:0] ps4mb_q;
  tlb_result_t        result_q [ENTRIES];

  // Valid bits: flush wins over a refill in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and payload write; a write racing a flush is harmless because the
  // entry's valid bit stays clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tag_vppn_q[i] <= '0;
        result_q[i]   <= '0;
      end
      tag_bit12_q <= '0;
      ps4mb_q     <= '0;
    end else if (wr_en) begin
      tag_vppn_q[wr_idx]  <= wr_vppn;
      tag_bit12_q[wr_idx] <= wr_bit12;
      ps4mb_q[wr_idx]     <= (wr_result.ps == PS_4MB);
      result_q[wr_idx]    <= wr_result;
    end
  end

  // Per-entry match against the live request.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      hit_vec[i] = valid_q[i] &
                   tag_match(lk_vppn, lk_bit12, tag_vppn_q[i], tag_bit12_q[i], ps4mb_q[i]);
    end
  end

  // One-hot to index; refill never creates a duplicate that is still
  // reachable through a hit, so an OR of indices is exact.
  always_comb begin
    hit_id = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (hit_vec[i]) begin
        hit_id = hit_id | IDW'(i);
      end
    end
  end

  assign rd_result = result_q[rd_id];

endmodule

// File: rtl/itlb_l0.sv
// L0 instruction TLB in front of main-TLB search port 0. Hits answer one
// cycle after accept from local entries; misses walk port 0, answer two
// cycles after accept and refill round-robin when the page was found.
module itlb_l0
  import itlb_l0_pkg::*;
#(
  parameter int ENTRIES = ITLB_L0_ENTRIES
) (
  input  logic       clk,
  input  logic       resetn,
  itlb_l0_if.slave   bus
);

  localparam int IDW = $clog2(ENTRIES);

  itlb_state_t        state_q;
  itlb_state_t        state_d;

  logic               req_ready;
  logic               accept;
  logic               cam_hit;
  logic               hit_accept;
  logic               miss_accept;
  logic               walk_done;
  logic               refill_en;

  logic [ENTRIES-1:0] hit_vec;
  logic [IDW-1:0]     hit_id;
  tlb_result_t        hit_result;

  logic [VPPN_W-1:0]  lat_vppn_q;
  logic               lat_bit12_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic               resp_valid_q;
  tlb_result_t        resp_result_q;

  itlb_l0_cam #(
    .ENTRIES (ENTRIES),
    .IDW     (IDW)
  ) u_cam (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (bus.flush),
    .wr_en     (refill_en),
    .wr_idx    (rr_ptr_q),
    .wr_vppn   (lat_vppn_q),
    .wr_bit12  (lat_bit12_q),
    .wr_result (resp_result_q),
    .lk_vppn   (bus.req_vppn),
    .lk_bit12  (bus.req_va_bit12),
    .hit_vec   (hit_vec),
    .hit_id    (hit_id),
    .rd_id     (hit_id),
    .rd_result (hit_result)
  );

  assign cam_hit = |hit_vec;

  // FSM state register; reset aborts any walk without a response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a flush during WALK repeats the walk, since the main
  // TLB contents change on that same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (miss_accept) state_d = S_WALK;
      S_WALK:  if (walk_done)   state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: accept only in IDLE without flush; refill only when the
  // walk found the page and no flush arrives in RESP.
  always_comb begin
    req_ready = 1'b0;
    walk_done = 1'b0;
    refill_en = 1'b0;
    case (state_q)
      S_IDLE:  req_ready = ~bus.flush;
      S_WALK:  walk_done = ~bus.flush;
      S_RESP:  refill_en = resp_result_q.found & ~bus.flush;
      default: ;
    endcase
    accept      = bus.req_valid & req_ready;
    hit_accept  = accept & cam_hit;
    miss_accept = accept & ~cam_hit;
  end

  // Request latch; it also drives port 0, so port 0 only moves on a miss.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_vppn_q  <= '0;
      lat_bit12_q <= 1'b0;
    end else if (miss_accept) begin
      lat_vppn_q  <= bus.req_vppn;
      lat_bit12_q <= bus.req_va_bit12;
    end
  end

  // Response register: the hit result on a hit accept, otherwise the
  // main-TLB answer sampled every WALK cycle (last one is used in RESP).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
    end else begin
      resp_valid_q <= hit_accept | walk_done;
      if (hit_accept) begin
        resp_result_q <= hit_result;
      end else if (state_q == S_WALK) begin
        resp_result_q <= bus.tlb_s0_result;
      end
    end
  end

  // Round-robin victim pointer, advanced once per refill.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q <= '0;
    end else if (refill_en) begin
      rr_ptr_q <= rr_ptr_q + IDW'(1);
    end
  end

  assign bus.req_ready       = req_ready;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_result     = resp_result_q;
  assign bus.tlb_s0_vppn     = lat_vppn_q;
  assign bus.tlb_s0_va_bit12 = lat_bit12_q;
  assign bus.dbg_state       = state_q;

endmodule
